// File: rtl/data_memory_write_merge.sv
// Write-merge buffer: gathers CPU word writes to one RAM line and issues a single masked line write.
// Optional idle auto-flush is compiled in with `define WRITE_MERGE_TIMEOUT_EN.

module write_merge_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic         clr,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] data,
    output logic         vld
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            vld  <= 1'b0;
        end else if (wr) begin
            data <= wdata;
            vld  <= 1'b1;
        end else if (clr) begin
            data <= '0;
            vld  <= 1'b0;
        end
    end
endmodule

module data_memory_write_merge #(
    parameter int RAM_DATA_SIZE    = 128,
    parameter int CPU_DATA_SIZE    = 32,
    parameter int ADDR_OFFSET_SIZE = 4,
    parameter int LINE_ADDR_SIZE   = 12,
    parameter int IDLE_TIMEOUT     = 8
) (
    input  logic                        IN_CLK,
    input  logic                        IN_RST,
    input  logic                        IN_WR_VALID,
    input  logic [LINE_ADDR_SIZE-1:0]   IN_WR_LINE,
    input  logic [ADDR_OFFSET_SIZE-1:0] IN_WR_OFFSET,
    input  logic [CPU_DATA_SIZE-1:0]    IN_WR_DATA,
    output logic                        OUT_WR_READY,
    input  logic                        IN_FLUSH,
    output logic                        OUT_RAM_WE,
    output logic [LINE_ADDR_SIZE-1:0]   OUT_RAM_LINE,
    output logic [RAM_DATA_SIZE-1:0]    OUT_RAM_DATA,
    output logic [3:0]                  OUT_RAM_MASK,
    input  logic                        IN_RAM_ACK,
    output logic                        OUT_BUSY
);
    localparam int SLOT_LSB = ADDR_OFFSET_SIZE / 2;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_FLUSH} state_t;

    state_t                          state, state_nxt;
    logic [LINE_ADDR_SIZE-1:0]       buf_line;
    logic [3:0][CPU_DATA_SIZE-1:0]   slot_data;
    logic [3:0]                      mask;
    logic [3:0]                      mask_nxt;
    logic [1:0]                      slot;
    logic                            line_hit;
    logic                            accept;
    logic                            ack_done;
    logic                            timeout;

    // Byte-within-word bits do not select anything.
    logic unused_offset_bits;
    assign unused_offset_bits = ^IN_WR_OFFSET[SLOT_LSB-1:0];

    assign slot     = IN_WR_OFFSET[SLOT_LSB +: 2];
    assign line_hit = (IN_WR_LINE == buf_line);
    assign accept   = IN_WR_VALID & OUT_WR_READY;
    assign mask_nxt = mask | (accept ? (4'b0001 << slot) : 4'b0000);
    assign ack_done = (state == S_FLUSH) & IN_RAM_ACK;

`ifdef WRITE_MERGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);
    logic [CNT_W-1:0] idle_cnt;

    always_ff @(posedge IN_CLK or posedge IN_RST) begin
        if (IN_RST)
            idle_cnt <= '0;
        else if (state != S_FILL || accept)
            idle_cnt <= '0;
        else if (!timeout)
            idle_cnt <= idle_cnt + 1'b1;
    end

    assign timeout = (state == S_FILL) && (idle_cnt == CNT_W'(IDLE_TIMEOUT));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge IN_CLK or posedge IN_RST) begin
        if (IN_RST)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_FILL;
            // A write that completes the line, a foreign line, a flush request or idle timeout all close the line.
            S_FILL:  if ((accept && mask_nxt == 4'b1111) || (IN_WR_VALID && !line_hit) || IN_FLUSH || timeout)
                         state_nxt = S_FLUSH;
            S_FLUSH: if (IN_RAM_ACK) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        OUT_WR_READY = 1'b0;
        OUT_RAM_WE   = 1'b0;
        OUT_BUSY     = 1'b1;
        case (state)
            S_IDLE:  begin
                OUT_WR_READY = 1'b1;
                OUT_BUSY     = 1'b0;
            end
            S_FILL:  OUT_WR_READY = line_hit;
            S_FLUSH: OUT_RAM_WE = 1'b1;
            default: OUT_BUSY = 1'b0;
        endcase
    end

    always_ff @(posedge IN_CLK or posedge IN_RST) begin
        if (IN_RST)
            buf_line <= '0;
        else if (state == S_IDLE && accept)
            buf_line <= IN_WR_LINE;
    end

    // Slots are cleared on acknowledge, so a fresh line starts from an all-zero buffer.
    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_slot
            write_merge_slot #(.W(CPU_DATA_SIZE)) u_slot (
                .clk   (IN_CLK),
                .rst   (IN_RST),
                .wr    (accept && (slot == 2'(k))),
                .clr   (ack_done),
                .wdata (IN_WR_DATA),
                .data  (slot_data[k]),
                .vld   (mask[k])
            );
        end
    endgenerate

    assign OUT_RAM_LINE = buf_line;
    assign OUT_RAM_DATA = slot_data;
    assign OUT_RAM_MASK = mask;
endmodule

// File: tb/tb_data_memory_write_merge.sv
// Randomized plus directed bench for data_memory_write_merge against a line-level reference model.
module tb_data_memory_write_merge;
    logic         IN_CLK = 1'b0;
    logic         IN_RST;
    logic         IN_WR_VALID;
    logic [11:0]  IN_WR_LINE;
    logic [3:0]   IN_WR_OFFSET;
    logic [31:0]  IN_WR_DATA;
    logic         OUT_WR_READY;
    logic         IN_FLUSH;
    logic         OUT_RAM_WE;
    logic [11:0]  OUT_RAM_LINE;
    logic [127:0] OUT_RAM_DATA;
    logic [3:0]   OUT_RAM_MASK;
    logic         IN_RAM_ACK;
    logic         OUT_BUSY;

    int checks = 0;
    int failures = 0;

    logic        m_open;
    logic [11:0] m_line;
    logic [31:0] m_words [4];
    logic [3:0]  m_mask;

    data_memory_write_merge dut (
        .IN_CLK(IN_CLK), .IN_RST(IN_RST), .IN_WR_VALID(IN_WR_VALID), .IN_WR_LINE(IN_WR_LINE),
        .IN_WR_OFFSET(IN_WR_OFFSET), .IN_WR_DATA(IN_WR_DATA), .OUT_WR_READY(OUT_WR_READY),
        .IN_FLUSH(IN_FLUSH), .OUT_RAM_WE(OUT_RAM_WE), .OUT_RAM_LINE(OUT_RAM_LINE),
        .OUT_RAM_DATA(OUT_RAM_DATA), .OUT_RAM_MASK(OUT_RAM_MASK), .IN_RAM_ACK(IN_RAM_ACK),
        .OUT_BUSY(OUT_BUSY)
    );

    always #5 IN_CLK = ~IN_CLK;

    task automatic tick();
        @(posedge IN_CLK);
        @(negedge IN_CLK);
    endtask

    function automatic logic [127:0] model_line();
        logic [127:0] r = '0;
        for (int k = 0; k < 4; k++)
            if (m_mask[k]) r = r | ({96'b0, m_words[k]} << (32 * k));
        return r;
    endfunction

    task automatic model_accept(input logic [11:0] line, input logic [3:0] off, input logic [31:0] data);
        int k;
        if (!m_open) begin
            m_open = 1'b1;
            m_line = line;
            m_mask = 4'b0;
            for (int j = 0; j < 4; j++) m_words[j] = '0;
        end
        k = int'(off[3:2]);
        m_words[k] = data;
        m_mask[k]  = 1'b1;
    endtask

    task automatic drive_write(input logic [11:0] line, input logic [3:0] off, input logic [31:0] data);
        IN_WR_VALID  = 1'b1;
        IN_WR_LINE   = line;
        IN_WR_OFFSET = off;
        IN_WR_DATA   = data;
    endtask

    task automatic test_reset();
        IN_RST = 1'b1; IN_WR_VALID = 0; IN_WR_LINE = 0; IN_WR_OFFSET = 0; IN_WR_DATA = 0;
        IN_FLUSH = 0; IN_RAM_ACK = 0;
        m_open = 0; m_mask = 0; m_line = 0;
        #3;
        checks++; if (OUT_RAM_WE !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", OUT_RAM_WE); end
        checks++; if (OUT_RAM_LINE !== 12'h0) begin failures++; $display("FAIL reset_line got=%h exp=0", OUT_RAM_LINE); end
        checks++; if (OUT_RAM_DATA !== 128'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", OUT_RAM_DATA); end
        checks++; if (OUT_RAM_MASK !== 4'h0) begin failures++; $display("FAIL reset_mask got=%b exp=0000", OUT_RAM_MASK); end
        checks++; if (OUT_BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", OUT_BUSY); end
        checks++; if (OUT_WR_READY !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", OUT_WR_READY); end
        @(negedge IN_CLK);
        IN_RST = 1'b0;
    endtask

    task automatic test_full_line();
        for (int i = 0; i < 4; i++) begin
            drive_write(12'h005, 4'(4 * i), 32'hA0 + 32'(i));
            tick();
            if (i < 3) begin
                checks++; if (OUT_RAM_WE !== 1'b0) begin failures++; $display("FAIL full_early_we i=%0d got=%b exp=0", i, OUT_RAM_WE); end
            end
        end
        IN_WR_VALID = 0;
        checks++; if (OUT_RAM_WE !== 1'b1) begin failures++; $display("FAIL full_we got=%b exp=1", OUT_RAM_WE); end
        checks++; if (OUT_RAM_DATA !== 128'h000000A3_000000A2_000000A1_000000A0)
            begin failures++; $display("FAIL full_data got=%h exp=000000a3000000a2000000a1000000a0", OUT_RAM_DATA); end
        checks++; if (OUT_RAM_MASK !== 4'b1111) begin failures++; $display("FAIL full_mask got=%b exp=1111", OUT_RAM_MASK); end
        checks++; if (OUT_RAM_LINE !== 12'h005) begin failures++; $display("FAIL full_line got=%h exp=005", OUT_RAM_LINE); end
        IN_RAM_ACK = 1; tick(); IN_RAM_ACK = 0;
        checks++; if (OUT_RAM_WE !== 1'b0 || OUT_BUSY !== 1'b0 || OUT_RAM_MASK !== 4'b0)
            begin failures++; $display("FAIL full_after_ack we=%b busy=%b mask=%b exp=0 0 0000", OUT_RAM_WE, OUT_BUSY, OUT_RAM_MASK); end
    endtask

    task automatic test_stall();
        drive_write(12'h005, 4'h4, 32'h11);
        tick();
        drive_write(12'h006, 4'h0, 32'h66);
        #1;
        checks++; if (OUT_WR_READY !== 1'b0) begin failures++; $display("FAIL stall_ready got=%b exp=0", OUT_WR_READY); end
        tick();
        checks++; if (OUT_RAM_WE !== 1'b1 || OUT_RAM_MASK !== 4'b0010 || OUT_RAM_LINE !== 12'h005)
            begin failures++; $display("FAIL stall_flush we=%b mask=%b line=%h exp=1 0010 005", OUT_RAM_WE, OUT_RAM_MASK, OUT_RAM_LINE); end
        checks++; if (OUT_RAM_DATA !== (128'h11 << 32)) begin failures++; $display("FAIL stall_data got=%h exp=%h", OUT_RAM_DATA, 128'h11 << 32); end
        IN_RAM_ACK = 1; tick(); IN_RAM_ACK = 0;
        checks++; if (OUT_WR_READY !== 1'b1 || OUT_RAM_WE !== 1'b0)
            begin failures++; $display("FAIL stall_post_ack ready=%b we=%b exp=1 0", OUT_WR_READY, OUT_RAM_WE); end
        tick();
        IN_WR_VALID = 0;
        checks++; if (OUT_BUSY !== 1'b1 || OUT_RAM_MASK !== 4'b0001 || OUT_RAM_LINE !== 12'h006)
            begin failures++; $display("FAIL stall_accept busy=%b mask=%b line=%h exp=1 0001 006", OUT_BUSY, OUT_RAM_MASK, OUT_RAM_LINE); end
        IN_FLUSH = 1; tick(); IN_FLUSH = 0;
        checks++; if (OUT_RAM_WE !== 1'b1 || OUT_RAM_DATA !== 128'h66)
            begin failures++; $display("FAIL stall_second_flush we=%b data=%h exp=1 66", OUT_RAM_WE, OUT_RAM_DATA); end
        IN_RAM_ACK = 1; tick(); IN_RAM_ACK = 0;
    endtask

    task automatic test_rewrite();
        drive_write(12'h007, 4'h8, 32'h1);
        tick();
        drive_write(12'h007, 4'h8, 32'h2);
        IN_FLUSH = 1;
        tick();
        IN_WR_VALID = 0; IN_FLUSH = 0;
        checks++; if (OUT_RAM_WE !== 1'b1 || OUT_RAM_MASK !== 4'b0100)
            begin failures++; $display("FAIL rewrite_mask we=%b mask=%b exp=1 0100", OUT_RAM_WE, OUT_RAM_MASK); end
        checks++; if (OUT_RAM_DATA !== (128'h2 << 64)) begin failures++; $display("FAIL rewrite_data got=%h exp=%h", OUT_RAM_DATA, 128'h2 << 64); end
        IN_RAM_ACK = 1; tick(); IN_RAM_ACK = 0;
    endtask

    task automatic test_ack_delay();
        logic [127:0] exp_data;
        m_open = 0;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] d = $urandom;
            drive_write(12'h009, 4'(4 * i + $urandom_range(0, 3)), d);
            model_accept(12'h009, 4'(4 * i), d);
            tick();
        end
        IN_WR_VALID = 0;
        exp_data = model_line();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (OUT_RAM_WE !== 1'b1 || OUT_RAM_LINE !== 12'h009 || OUT_RAM_DATA !== exp_data ||
                OUT_RAM_MASK !== 4'b1111 || OUT_WR_READY !== 1'b0) begin
                failures++;
                $display("FAIL ack_delay_hold c=%0d we=%b line=%h mask=%b ready=%b data=%h exp=1 009 1111 0 %h",
                         c, OUT_RAM_WE, OUT_RAM_LINE, OUT_RAM_MASK, OUT_WR_READY, OUT_RAM_DATA, exp_data);
            end
            tick();
        end
        IN_RAM_ACK = 1; tick(); IN_RAM_ACK = 0;
        m_open = 0;
        checks++; if (OUT_RAM_WE !== 1'b0) begin failures++; $display("FAIL ack_delay_release got=%b exp=0", OUT_RAM_WE); end
    endtask

    task automatic test_random();
        logic [11:0] line;
        logic [3:0]  off;
        logic [31:0] data;
        logic        fl, was_open, hit, exp_flush;
        logic [127:0] exp_data;
        m_open = 0; m_mask = 0;
        for (int it = 0; it < 60; it++) begin
            was_open = m_open;
            if (m_open && $urandom_range(0, 3) != 0) line = m_line;
            else line = 12'(12'h100 + $urandom_range(0, 7));
            off  = 4'($urandom_range(0, 15));
            data = $urandom;
            fl   = ($urandom_range(0, 5) == 0);
            hit  = !was_open || (line == m_line);
            drive_write(line, off, data);
            IN_FLUSH = fl;
            #1;
            checks++; if (OUT_WR_READY !== hit) begin failures++; $display("FAIL rand_ready it=%0d got=%b exp=%b", it, OUT_WR_READY, hit); end
            tick();
            IN_FLUSH = 0;
            if (hit) begin
                model_accept(line, off, data);
                IN_WR_VALID = 0;
                exp_flush = (m_mask == 4'b1111) || (was_open && fl);
            end else begin
                exp_flush = 1'b1;
            end
            if (exp_flush) begin
                int dly = $urandom_range(0, 3);
                exp_data = model_line();
                for (int c = 0; c <= dly; c++) begin
                    checks++;
                    if (OUT_RAM_WE !== 1'b1 || OUT_RAM_LINE !== m_line || OUT_RAM_MASK !== m_mask ||
                        OUT_RAM_DATA !== exp_data || OUT_WR_READY !== 1'b0) begin
                        failures++;
                        $display("FAIL rand_flush it=%0d c=%0d we=%b line=%h mask=%b ready=%b data=%h exp line=%h mask=%b data=%h",
                                 it, c, OUT_RAM_WE, OUT_RAM_LINE, OUT_RAM_MASK, OUT_WR_READY, OUT_RAM_DATA, m_line, m_mask, exp_data);
                    end
                    if (c < dly) tick();
                end
                IN_RAM_ACK = 1; tick(); IN_RAM_ACK = 0;
                m_open = 0; m_mask = 0;
                checks++; if (OUT_RAM_WE !== 1'b0 || OUT_BUSY !== 1'b0)
                    begin failures++; $display("FAIL rand_ack it=%0d we=%b busy=%b exp=0 0", it, OUT_RAM_WE, OUT_BUSY); end
                if (!hit) begin
                    tick();
                    model_accept(line, off, data);
                    IN_WR_VALID = 0;
                end
            end else begin
                checks++;
                if (OUT_RAM_WE !== 1'b0 || OUT_RAM_MASK !== m_mask || OUT_BUSY !== 1'b1) begin
                    failures++;
                    $display("FAIL rand_fill it=%0d we=%b mask=%b busy=%b exp=0 %b 1", it, OUT_RAM_WE, OUT_RAM_MASK, OUT_BUSY, m_mask);
                end
            end
        end
        if (m_open) begin
            exp_data = model_line();
            IN_FLUSH = 1; tick(); IN_FLUSH = 0;
            checks++; if (OUT_RAM_WE !== 1'b1 || OUT_RAM_DATA !== exp_data)
                begin failures++; $display("FAIL rand_final we=%b data=%h exp=1 %h", OUT_RAM_WE, OUT_RAM_DATA, exp_data); end
            IN_RAM_ACK = 1; tick(); IN_RAM_ACK = 0;
            m_open = 0;
        end
    endtask

    task automatic test_timeout();
        int rise = 0;
        drive_write(12'h00A, 4'h0, 32'h5A);
        tick();
        IN_WR_VALID = 0;
        for (int i = 1; i <= 20 && rise == 0; i++) begin
            tick();
            if (OUT_RAM_WE === 1'b1) rise = i;
        end
`ifdef WRITE_MERGE_TIMEOUT_EN
        checks++; if (rise != 9) begin failures++; $display("FAIL timeout_rise got=%0d exp=9", rise); end
`else
        checks++; if (rise != 0) begin failures++; $display("FAIL timeout_rise got=%0d exp=0 (never)", rise); end
        IN_FLUSH = 1; tick(); IN_FLUSH = 0;
`endif
        IN_RAM_ACK = 1; tick(); IN_RAM_ACK = 0;
    endtask

    task automatic test_reset_flush();
        drive_write(12'h00B, 4'hC, 32'hBEEF);
        tick();
        IN_WR_VALID = 0;
        IN_FLUSH = 1; tick(); IN_FLUSH = 0;
        checks++; if (OUT_RAM_WE !== 1'b1) begin failures++; $display("FAIL rstflush_pre got=%b exp=1", OUT_RAM_WE); end
        #1 IN_RST = 1;
        #1;
        checks++; if (OUT_RAM_WE !== 1'b0 || OUT_RAM_MASK !== 4'b0 || OUT_BUSY !== 1'b0)
            begin failures++; $display("FAIL rstflush_async we=%b mask=%b busy=%b exp=0 0000 0", OUT_RAM_WE, OUT_RAM_MASK, OUT_BUSY); end
        @(negedge IN_CLK);
        IN_RST = 0;
        IN_RAM_ACK = 1; tick(); IN_RAM_ACK = 0;
        checks++; if (OUT_RAM_WE !== 1'b0 || OUT_BUSY !== 1'b0 || OUT_RAM_DATA !== 128'h0)
            begin failures++; $display("FAIL rstflush_ack we=%b busy=%b data=%h exp=0 0 0", OUT_RAM_WE, OUT_BUSY, OUT_RAM_DATA); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_line();
        test_stall();
        test_rewrite();
        test_ack_delay();
        test_random();
        test_timeout();
        test_reset_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
